// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit: opcode classes, R-type funct codes,
// ALU control words and the sequencing FSM states.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_AND     = 4'b0010;
    localparam logic [3:0] ALU_OR      = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SLT     = 4'b0101;
    localparam logic [3:0] ALU_SLL     = 4'b0110;
    localparam logic [3:0] ALU_SRL     = 4'b0111;
    localparam logic [3:0] ALU_MUL     = 4'b1000;
    localparam logic [3:0] ALU_DIV     = 4'b1001;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        VALID = 2'b01,
        BUSY  = 2'b10
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Handshake bundle between the ID-stage decoder (master) and the ALU control unit (slave).
interface alu_ctrl_if #(
    parameter int OPW = 3,
    parameter int FW  = 6,
    parameter int CW  = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] alu_opcode;
    logic [FW-1:0]  funct;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  alu_ctrl;
    logic           illegal;
    logic           busy;

    modport master (
        output in_valid, alu_opcode, funct, out_ready,
        input  in_ready, out_valid, alu_ctrl, illegal, busy
    );

    modport slave (
        input  in_valid, alu_opcode, funct, out_ready,
        output in_ready, out_valid, alu_ctrl, illegal, busy
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode class (and funct for R-type) into an ALU control word,
// flagging unknown encodings and the multi-cycle MUL/DIV operations.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPW = 3,
    parameter int FW  = 6,
    parameter int CW  = 4
) (
    input  logic [OPW-1:0] alu_opcode,
    input  logic [FW-1:0]  funct,
    output logic [CW-1:0]  alu_ctrl,
    output logic           illegal,
    output logic           is_mul,
    output logic           is_div
);

    logic [3:0] code;

    always_comb begin
        code    = ALU_ILLEGAL;
        illegal = 1'b1;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (alu_opcode)
            OPW'(OP_ADD): begin code = ALU_ADD; illegal = 1'b0; end
            OPW'(OP_SUB): begin code = ALU_SUB; illegal = 1'b0; end
            OPW'(OP_AND): begin code = ALU_AND; illegal = 1'b0; end
            OPW'(OP_OR):  begin code = ALU_OR;  illegal = 1'b0; end
            OPW'(OP_SLT): begin code = ALU_SLT; illegal = 1'b0; end
            OPW'(OP_RTYPE): begin
                illegal = 1'b0;
                case (funct)
                    FW'(FN_ADD): code = ALU_ADD;
                    FW'(FN_SUB): code = ALU_SUB;
                    FW'(FN_AND): code = ALU_AND;
                    FW'(FN_OR):  code = ALU_OR;
                    FW'(FN_XOR): code = ALU_XOR;
                    FW'(FN_SLT): code = ALU_SLT;
                    FW'(FN_SLL): code = ALU_SLL;
                    FW'(FN_SRL): code = ALU_SRL;
                    FW'(FN_MUL): begin code = ALU_MUL; is_mul = 1'b1; end
                    FW'(FN_DIV): begin code = ALU_DIV; is_div = 1'b1; end
                    default:     illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_ctrl = CW'(code);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage: decodes on accept, holds the result until consumed,
// and stalls MUL/DIV for their fixed latency before presenting them.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int FW      = 6,
    parameter int CW      = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    alu_ctrl_if.slave  bus
);

    localparam int MAX_LAT = max_int(MUL_LAT, DIV_LAT);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CW-1:0]    ctrl_reg, ctrl_next;
    logic             ill_reg, ill_next;

    logic [CW-1:0]    dec_ctrl;
    logic             dec_ill, dec_mul, dec_div;
    logic             accept;

    alu_ctrl_decode #(
        .OPW (OPW),
        .FW  (FW),
        .CW  (CW)
    ) u_decode (
        .alu_opcode (bus.alu_opcode),
        .funct      (bus.funct),
        .alu_ctrl   (dec_ctrl),
        .illegal    (dec_ill),
        .is_mul     (dec_mul),
        .is_div     (dec_div)
    );

    // out_ready only reaches in_ready while a result is being presented
    assign bus.in_ready  = (state_reg == IDLE) | ((state_reg == VALID) & bus.out_ready);
    assign bus.out_valid = (state_reg == VALID);
    assign bus.busy      = (state_reg == BUSY);
    assign bus.alu_ctrl  = ctrl_reg;
    assign bus.illegal   = ill_reg;
    assign accept        = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            ctrl_reg  <= '0;
            ill_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ctrl_reg  <= ctrl_next;
            ill_reg   <= ill_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ctrl_next  = ctrl_reg;
        ill_next   = ill_reg;
        if (flush) begin
            state_next = IDLE;
            count_next = '0;
        end else if (accept) begin
            ctrl_next = dec_ctrl;
            ill_next  = dec_ill;
            if (dec_mul) begin
                state_next = BUSY;
                count_next = MUL_LOAD;
            end else if (dec_div) begin
                state_next = BUSY;
                count_next = DIV_LOAD;
            end else begin
                state_next = VALID;
                count_next = '0;
            end
        end else begin
            case (state_reg)
                VALID: if (bus.out_ready) state_next = IDLE;
                BUSY: begin
                    if (count_reg == '0) state_next = VALID;
                    else                 count_next = count_reg - CNT_W'(1);
                end
                IDLE:    ;
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: table of opcode/funct vectors against a scoreboard,
// plus hand-written reset, stream, backpressure, multi-cycle and flush sequences.
module tb_alu_ctrl_pipe;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
    localparam int NV      = 19;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
        logic       ill;
        int         lat;
    } vec_t;

    typedef struct {
        logic [3:0] ctrl;
        logic       ill;
        int         lat;
        int         t_acc;
        bit         chk;
    } sb_t;

    logic clk;
    logic rst_n;
    logic flush;

    alu_ctrl_if #(.OPW(3), .FW(6), .CW(4)) bus ();

    alu_ctrl_pipe #(
        .OPW     (3),
        .FW      (6),
        .CW      (4),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    sb_t  sb[$];
    vec_t vecs[NV];

    logic [3:0] drv_ctrl;
    logic       drv_ill;
    int         drv_lat;
    bit         drv_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [5:0] fn, input logic [3:0] ctrl,
                          input logic ill, input int lat, input bit chk);
        bus.in_valid   = 1'b1;
        bus.alu_opcode = op;
        bus.funct      = fn;
        drv_ctrl       = ctrl;
        drv_ill        = ill;
        drv_lat        = lat;
        drv_chk        = chk;
    endtask

    // Hold the op until the unit takes it, bounded
    task automatic drive_op(input vec_t v, input bit chk);
        bit acc;
        acc = 1'b0;
        set_op(v.op, v.fn, v.ctrl, v.ill, v.lat, chk);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic quiet_window(input string name);
        int seen;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        tick();
        check(name, seen, 0);
    endtask

    task automatic run_multi(input logic [5:0] fn, input logic [3:0] code, input int lat);
        set_op(3'b010, fn, code, 1'b0, lat + 1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check("md_busy", bus.busy, 1'b1);
            check("md_in_ready", bus.in_ready, 1'b0);
            check("md_out_valid_low", bus.out_valid, 1'b0);
            tick();
        end
        check("md_out_valid", bus.out_valid, 1'b1);
        check("md_alu_ctrl", bus.alu_ctrl, code);
        check("md_busy_done", bus.busy, 1'b0);
        tick();
        drain();
    endtask

    task automatic start_div_to_cycle3();
        set_op(3'b010, 6'b011010, 4'b1001, 1'b0, DIV_LAT + 1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("div_busy_pre_kill", bus.busy, 1'b1);
    endtask

    // Scoreboard monitor: observe handshakes mid-cycle, when inputs and outputs are stable
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && !flush) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("alu_ctrl", bus.alu_ctrl, e.ctrl);
                        check("illegal", bus.illegal, e.ill);
                        if (e.chk) check("latency", cyc - e.t_acc, e.lat);
                        $display("txn: alu_ctrl=%b illegal=%b latency=%0d", bus.alu_ctrl,
                                 bus.illegal, cyc - e.t_acc);
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    e.ctrl  = drv_ctrl;
                    e.ill   = drv_ill;
                    e.lat   = drv_lat;
                    e.t_acc = cyc;
                    e.chk   = drv_chk;
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b000, 6'b011000, 4'b0000, 1'b0, 1};
        vecs[1]  = '{3'b001, 6'b011010, 4'b0001, 1'b0, 1};
        vecs[2]  = '{3'b011, 6'b000000, 4'b0010, 1'b0, 1};
        vecs[3]  = '{3'b100, 6'b111111, 4'b0011, 1'b0, 1};
        vecs[4]  = '{3'b111, 6'b100000, 4'b0101, 1'b0, 1};
        vecs[5]  = '{3'b101, 6'b100000, 4'b1111, 1'b1, 1};
        vecs[6]  = '{3'b110, 6'b011000, 4'b1111, 1'b1, 1};
        vecs[7]  = '{3'b010, 6'b100000, 4'b0000, 1'b0, 1};
        vecs[8]  = '{3'b010, 6'b100010, 4'b0001, 1'b0, 1};
        vecs[9]  = '{3'b010, 6'b100100, 4'b0010, 1'b0, 1};
        vecs[10] = '{3'b010, 6'b100101, 4'b0011, 1'b0, 1};
        vecs[11] = '{3'b010, 6'b100110, 4'b0100, 1'b0, 1};
        vecs[12] = '{3'b010, 6'b101010, 4'b0101, 1'b0, 1};
        vecs[13] = '{3'b010, 6'b000000, 4'b0110, 1'b0, 1};
        vecs[14] = '{3'b010, 6'b000010, 4'b0111, 1'b0, 1};
        vecs[15] = '{3'b010, 6'b011000, 4'b1000, 1'b0, MUL_LAT + 1};
        vecs[16] = '{3'b010, 6'b011010, 4'b1001, 1'b0, DIV_LAT + 1};
        vecs[17] = '{3'b010, 6'b111111, 4'b1111, 1'b1, 1};
        vecs[18] = '{3'b010, 6'b000001, 4'b1111, 1'b1, 1};

        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.out_ready  = 1'b1;
        set_op(3'b000, 6'b000000, 4'b0000, 1'b0, 1, 1'b1);

        // Reset with in_valid asserted
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_alu_ctrl", bus.alu_ctrl, 4'b0000);
        check("rst_illegal", bus.illegal, 1'b0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_sb_empty", sb.size(), 0);
        tick();

        // Table of opcode/funct vectors, streamed with out_ready high
        for (int i = 0; i < NV; i++) drive_op(vecs[i], 1'b1);
        bus.in_valid = 1'b0;
        drain();

        // Back-to-back stream
        set_op(3'b010, 6'b100000, 4'b0000, 1'b0, 1, 1'b1);
        #1 check("stream_ready0", bus.in_ready, 1'b1);
        tick();
        set_op(3'b011, 6'b000000, 4'b0010, 1'b0, 1, 1'b1);
        #1 check("stream_ready1", bus.in_ready, 1'b1);
        tick();
        set_op(3'b111, 6'b000000, 4'b0101, 1'b0, 1, 1'b1);
        #1 check("stream_ready2", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        drain();

        // Backpressure, with a second op waiting behind the stalled one
        bus.out_ready = 1'b0;
        set_op(3'b001, 6'b000000, 4'b0001, 1'b0, 1, 1'b0);
        tick();
        set_op(3'b100, 6'b000000, 4'b0011, 1'b0, 1, 1'b0);
        repeat (3) begin
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_alu_ctrl", bus.alu_ctrl, 4'b0001);
            check("bp_in_ready", bus.in_ready, 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_next_alu_ctrl", bus.alu_ctrl, 4'b0011);
        drain();

        // Multi-cycle ops
        run_multi(6'b011000, 4'b1000, MUL_LAT);
        run_multi(6'b011010, 4'b1001, DIV_LAT);

        // Illegal ops take latency 1
        drive_op(vecs[5], 1'b1);
        drive_op(vecs[17], 1'b1);
        drain();

        // Flush mid-DIV, with a competing op offered in the flush cycle
        start_div_to_cycle3();
        flush = 1'b1;
        set_op(3'b000, 6'b000000, 4'b0000, 1'b0, 1, 1'b1);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_busy", bus.busy, 1'b0);
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_in_ready", bus.in_ready, 1'b1);
        sb.delete();
        quiet_window("flush_no_output");

        // Reset mid-DIV
        start_div_to_cycle3();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstdiv_busy", bus.busy, 1'b0);
        check("rstdiv_out_valid", bus.out_valid, 1'b0);
        check("rstdiv_alu_ctrl", bus.alu_ctrl, 4'b0000);
        check("rstdiv_in_ready", bus.in_ready, 1'b1);
        sb.delete();
        quiet_window("rstdiv_no_output");

        // Unit still works after the kills
        drive_op(vecs[11], 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
